segment_feeder: RTL and testbench

SEGMENT_FEEDER -- requirements
Module: segment_feeder

---
 rtl/segment_feeder_pkg.sv | 33 +++
 rtl/segment_feeder.sv | 187 ++++++++++++++++++
 tb/tb_segment_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_feeder_pkg.sv
// segment_feeder_pkg -- shared types and constants for the segment feeder.
//   coord_t          : 8-bit unsigned coordinate
//   vertex_t         : packed {x, y, z} toolpath vertex
//   state_e          : feeder FSM state encoding
//   DEFAULT_MAX_SEGS : default collision-detector segment capacity
//   vtx_eq()         : all-axis vertex equality (degenerate-segment test)
package segment_feeder_pkg;

  localparam int unsigned DEFAULT_MAX_SEGS = 51;

  typedef logic [7:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PT,
    ISSUE,
    CHECK,
    GAP,
    DONE,
    FULL
  } state_e;

  function automatic logic vtx_eq(input vertex_t a, input vertex_t b);
    return (a.x == b.x) && (a.y == b.y) && (a.z == b.z);
  endfunction

endpackage

// File: rtl/segment_feeder.sv
// segment_feeder -- turns a stream of toolpath vertices into line segments
// for a collision detector and reports the detector's verdict.
//
// Parameters
//   MAX_SEGS   : detector segment capacity; FULL is entered once reached (<=255)
//   GAP_CYCLES : idle cycles inserted after each CHECK (0-15)
// Ports
//   clk, reset                 : clock (rising edge), async active-low reset
//   pt_valid/pt_ready          : vertex handshake
//   pt_x/pt_y/pt_z, pt_last    : vertex coordinates, last-vertex-of-path flag
//   seg_val, x1..z2            : one-cycle segment strobe + endpoints
//   det_val, det_id            : detector verdict, sampled in the cycle after seg_val
//   hit, hit_id                : one-cycle hit pulse, id of the colliding segment
//   seg_count, hit_count       : segments issued, hits seen (if enabled)
//   busy, full, done           : status; done is a one-cycle end-of-path pulse
// Configuration
//   SEGMENT_FEEDER_HIT_COUNT_EN : when defined, hit_count is a saturating
//                                 hit counter; otherwise it is tied to 0.
module segment_feeder #(
  parameter int unsigned MAX_SEGS   = segment_feeder_pkg::DEFAULT_MAX_SEGS,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pt_valid,
  output logic       pt_ready,
  input  logic [7:0] pt_x,
  input  logic [7:0] pt_y,
  input  logic [7:0] pt_z,
  input  logic       pt_last,
  output logic       seg_val,
  output logic [7:0] x1,
  output logic [7:0] y1,
  output logic [7:0] z1,
  output logic [7:0] x2,
  output logic [7:0] y2,
  output logic [7:0] z2,
  input  logic       det_val,
  input  logic [7:0] det_id,
  output logic       hit,
  output logic [7:0] hit_id,
  output logic [7:0] seg_count,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic [7:0] hit_count
);
  import segment_feeder_pkg::*;

  localparam logic [7:0] MAX_SEGS_C = 8'(MAX_SEGS);
  localparam logic [3:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic       HAS_GAP    = (GAP_CYCLES != 0);

  state_e     state_q, state_d, after_seg;
  vertex_t    cur_vtx, prev_q, seg_a_q, seg_b_q;
  logic       prev_vld_q, last_q, rdy_en_q, hit_q;
  logic [7:0] seg_cnt_q, hit_id_q;
  logic [3:0] gap_q;
  logic       accept, store_only, degenerate;

  assign cur_vtx = {pt_x, pt_y, pt_z};

  always_comb begin
    // rdy_en_q keeps pt_ready low during reset and until the first clock after it.
    pt_ready   = rdy_en_q && ((state_q == IDLE) || (state_q == WAIT_PT));
    accept     = pt_valid && pt_ready;
    store_only = (state_q == IDLE) || !prev_vld_q;
    degenerate = !store_only && vtx_eq(cur_vtx, prev_q);

    if (seg_cnt_q == MAX_SEGS_C) begin
      after_seg = FULL;
    end else if (last_q) begin
      after_seg = DONE;
    end else begin
      after_seg = WAIT_PT;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT_PT: begin
        if (accept) begin
          if (store_only || degenerate) begin
            state_d = pt_last ? DONE : WAIT_PT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE:   state_d = CHECK;
      CHECK:   state_d = HAS_GAP ? GAP : after_seg;
      GAP:     if (gap_q == '0) state_d = after_seg;
      DONE:    state_d = IDLE;
      FULL:    state_d = FULL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      seg_a_q    <= '0;
      seg_b_q    <= '0;
      last_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
      seg_cnt_q  <= '0;
      hit_q      <= 1'b0;
      hit_id_q   <= '0;
      gap_q      <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      hit_q    <= 1'b0;

      // Endpoints are latched at accept time so they are already stable in
      // ISSUE; the end vertex becomes prev at that same moment.
      if (accept) begin
        if (store_only) begin
          prev_q     <= cur_vtx;
          prev_vld_q <= 1'b1;
        end else if (!degenerate) begin
          seg_a_q <= prev_q;
          seg_b_q <= cur_vtx;
          prev_q  <= cur_vtx;
          last_q  <= pt_last;
        end
      end

      if ((state_q == ISSUE) && (seg_cnt_q != '1)) begin
        seg_cnt_q <= seg_cnt_q + 8'd1;
      end

      if ((state_q == CHECK) && det_val) begin
        hit_q    <= 1'b1;
        hit_id_q <= det_id;
      end

      if (state_q == CHECK) begin
        gap_q <= GAP_LOAD;
      end else if ((state_q == GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - 4'd1;
      end

      if (state_q == DONE) begin
        prev_vld_q <= 1'b0;
      end
    end
  end

`ifdef SEGMENT_FEEDER_HIT_COUNT_EN
  logic [7:0] hit_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q <= '0;
    end else if ((state_q == CHECK) && det_val && (hit_cnt_q != '1)) begin
      hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = '0;
`endif

  assign seg_val   = (state_q == ISSUE);
  assign x1        = seg_a_q.x;
  assign y1        = seg_a_q.y;
  assign z1        = seg_a_q.z;
  assign x2        = seg_b_q.x;
  assign y2        = seg_b_q.y;
  assign z2        = seg_b_q.z;
  assign hit       = hit_q;
  assign hit_id    = hit_id_q;
  assign seg_count = seg_cnt_q;
  assign busy      = (state_q != IDLE) && (state_q != FULL);
  assign full      = (state_q == FULL);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_segment_feeder.sv
// tb_segment_feeder -- self-checking bench for segment_feeder.
// u_dut uses default parameters; u_small uses MAX_SEGS=3, GAP_CYCLES=3.
module tb_segment_feeder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pt_x = '0, pt_y = '0, pt_z = '0;
  logic       pt_last  = 1'b0;
  logic       pt_valid = 1'b0;
  logic       s_valid  = 1'b0;
  logic       det_val  = 1'b0;
  logic [7:0] det_id   = '0;
  logic       s_det_val = 1'b0;
  logic [7:0] s_det_id  = '0;

  logic       pt_ready, seg_val, hit, busy, full, done;
  logic [7:0] x1, y1, z1, x2, y2, z2, hit_id, seg_count, hit_count;
  logic       s_ready, s_seg_val, s_hit, s_busy, s_full, s_done;
  logic [7:0] s_x1, s_y1, s_z1, s_x2, s_y2, s_z2, s_hit_id, s_seg_count, s_hit_count;

  segment_feeder u_dut (
    .clk(clk), .reset(reset), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
    .seg_val(seg_val), .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .det_val(det_val), .det_id(det_id), .hit(hit), .hit_id(hit_id),
    .seg_count(seg_count), .busy(busy), .full(full), .done(done),
    .hit_count(hit_count)
  );

  segment_feeder #(.MAX_SEGS(3), .GAP_CYCLES(3)) u_small (
    .clk(clk), .reset(reset), .pt_valid(s_valid), .pt_ready(s_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
    .seg_val(s_seg_val), .x1(s_x1), .y1(s_y1), .z1(s_z1), .x2(s_x2), .y2(s_y2), .z2(s_z2),
    .det_val(s_det_val), .det_id(s_det_id), .hit(s_hit), .hit_id(s_hit_id),
    .seg_count(s_seg_count), .busy(s_busy), .full(s_full), .done(s_done),
    .hit_count(s_hit_count)
  );

`ifdef SEGMENT_FEEDER_HIT_COUNT_EN
  localparam int HC_ONE = 1;
`else
  localparam int HC_ONE = 0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- path-level reference model ----------------
  bit          have_prev = 0;
  logic [23:0] mprev = '0;
  int          m_segs = 0, m_done = 0;
  logic [47:0] exp_q[$];

  task automatic model_accept(input logic [23:0] v, input bit last);
    if (!have_prev) begin
      have_prev = 1;
      mprev = v;
    end else if (v != mprev) begin
      exp_q.push_back({mprev, v});
      mprev = v;
      m_segs++;
    end
    if (last) begin
      have_prev = 0;
      m_done++;
    end
  endtask

  // ---------------- detector model + output monitor (u_dut) ----------------
  typedef struct packed { logic v; logic [7:0] id; } det_t;
  det_t       plan_q[$];
  bit         noise_en = 0;
  bit         pend = 0;
  logic       pv = 1'b0, exp_hit = 1'b0;
  logic [7:0] pid = '0, exp_hit_id = '0, exp_hc = '0;
  int         hits_seen = 0, dones_seen = 0, segs_seen = 0, last_seg_cyc = -100;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0; exp_hit = 0; exp_hit_id = '0; exp_hc = '0;
        det_val = 1'b0; last_seg_cyc = -100;
      end else begin
        chk("hit", hit, exp_hit);
        chk("hit_id", hit_id, exp_hit_id);
        chk("hit_count", hit_count, exp_hc);
        if (hit) hits_seen++;
        if (done) dones_seen++;
        // Outside the CHECK window the detector lines carry noise.
        det_val = noise_en ? 1'($urandom) : 1'b0;
        det_id  = 8'($urandom);
        exp_hit = 1'b0;
        if (pend) begin
          det_val = pv;
          det_id  = pid;
          if (pv) begin
            exp_hit = 1'b1;
            exp_hit_id = pid;
            if (HC_ONE == 1 && exp_hc != 8'hFF) exp_hc++;
          end
          pend = 0;
        end
        if (seg_val) begin
          segs_seen++;
          chk("seg_spacing", 64'((cyc - last_seg_cyc) >= 4), 64'd1);
          last_seg_cyc = cyc;
          chk("seg_expected_pending", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) chk("seg_ends", {x1, y1, z1, x2, y2, z2}, exp_q.pop_front());
          if (plan_q.size() != 0) begin
            {pv, pid} = plan_q.pop_front();
          end else begin
            pv  = ($urandom_range(0, 2) == 0);
            pid = 8'($urandom);
          end
          pend = 1;
        end
      end
    end
  end

  // u_small seg_val monitor
  int s_segs = 0;
  int s_seg_cyc[$];
  initial begin
    forever begin
      @(negedge clk);
      if (reset && s_seg_val) begin
        s_segs++;
        s_seg_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit sel, input logic [7:0] x, y, z, input bit last,
                      input int max_wait, output bit ok);
    int n;
    pt_x = x; pt_y = y; pt_z = z; pt_last = last;
    if (sel) s_valid = 1'b1; else pt_valid = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < max_wait) begin
      if ((sel ? s_ready : pt_ready) === 1'b1) ok = 1;
      else begin @(posedge clk); #1; n++; end
    end
    if (ok) begin
      if (!sel) model_accept({x, y, z}, last);
      @(posedge clk); #1;
    end
    pt_valid = 1'b0;
    s_valid  = 1'b0;
  endtask

  task automatic send0(input logic [7:0] x, y, z, input bit last);
    bit ok;
    send(1'b0, x, y, z, last, 200, ok);
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic send1(input logic [7:0] x, y, z, input bit last);
    bit ok;
    send(1'b1, x, y, z, last, 200, ok);
    chk("send_small_accept", 64'(ok), 64'd1);
  endtask

  task automatic clear_model();
    exp_q.delete(); plan_q.delete(); s_seg_cyc.delete();
    have_prev = 0; m_segs = 0; m_done = 0;
    dones_seen = 0; segs_seen = 0; hits_seen = 0; s_segs = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; pt_valid = 1'b0; s_valid = 1'b0;
    tick(2);
    clear_model();
    reset = 1'b1;
    tick(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_seg"}, {x1, y1, z1, x2, y2, z2}, 64'd0);
    chk({tag, "_ctl"}, {seg_val, hit, hit_id, seg_count, hit_count, full, done, pt_ready, busy}, 64'd0);
    chk({tag, "_small"}, {s_seg_val, s_x1, s_x2, s_seg_count, s_full, s_done, s_ready, s_busy}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int acc;
    logic [7:0] rx, ry, rz;
    bit rl;

    // Reset state and pt_ready release timing
    tick(3);
    chk_zero("reset");
    reset = 1'b1;
    #1;
    chk("ready_before_first_clk", 64'(pt_ready), 64'd0);
    tick(1);
    chk("ready_after_first_clk", 64'(pt_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // Two-segment path with a hit reported on the second segment
    plan_q.push_back('{v: 1'b0, id: 8'd0});
    plan_q.push_back('{v: 1'b1, id: 8'd2});
    send0(8'd0, 8'd0, 8'd0, 1'b0);
    send0(8'd10, 8'd10, 8'd0, 1'b0);
    send0(8'd10, 8'd0, 8'd0, 1'b1);
    tick(10);
    chk("p1_seg_count", seg_count, 64'd2);
    chk("p1_segs_seen", 64'(segs_seen), 64'd2);
    chk("p1_done", 64'(dones_seen), 64'd1);
    chk("p1_hits", 64'(hits_seen), 64'd1);
    chk("p1_hit_id", hit_id, 64'd2);
    chk("p1_hit_count", hit_count, 64'(HC_ONE));
    chk("p1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("p1_idle_busy", 64'(busy), 64'd0);

    // Degenerate segment suppressed
    do_reset();
    send0(8'd5, 8'd5, 8'd5, 1'b0);
    send0(8'd5, 8'd5, 8'd5, 1'b0);
    send0(8'd6, 8'd6, 8'd6, 1'b1);
    tick(10);
    chk("degen_seg_count", seg_count, 64'd1);
    chk("degen_segs_seen", 64'(segs_seen), 64'd1);
    chk("degen_done", 64'(dones_seen), 64'd1);

    // Reset pulse during CHECK aborts the segment
    do_reset();
    send0(8'd1, 8'd1, 8'd1, 1'b0);
    send0(8'd2, 8'd2, 8'd2, 1'b0);
    tick(1);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    chk("pre_abort_count", seg_count, 64'd1);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    @(posedge clk); #1;
    clear_model();
    reset = 1'b1;
    tick(1);
    send0(8'd20, 8'd20, 8'd20, 1'b0);
    tick(8);
    chk("abort_no_seg", 64'(segs_seen), 64'd0);
    chk("abort_no_hit", 64'(hits_seen), 64'd0);
    chk("abort_seg_count", seg_count, 64'd0);
    send0(8'd20, 8'd20, 8'd20, 1'b1);
    tick(4);
    chk("abort_done", 64'(dones_seen), 64'd1);
    chk("abort_still_no_seg", 64'(segs_seen), 64'd0);

    // Randomized paths against the model
    do_reset();
    noise_en = 1;
    for (int it = 0; it < 300 && m_segs < 40; it++) begin
      if (have_prev && $urandom_range(0, 3) == 0) begin
        {rx, ry, rz} = mprev;
      end else if ($urandom_range(0, 1) == 0) begin
        rx = 8'($urandom_range(0, 3)); ry = 8'($urandom_range(0, 3)); rz = 8'($urandom_range(0, 3));
      end else begin
        rx = 8'($urandom); ry = 8'($urandom); rz = 8'($urandom);
      end
      rl = ($urandom_range(0, 5) == 0);
      tick($urandom_range(0, 2));
      send0(rx, ry, rz, rl);
    end
    tick(12);
    noise_en = 0;
    tick(2);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_seg_count", seg_count, 64'(m_segs));
    chk("rand_segs_seen", 64'(segs_seen), 64'(m_segs));
    chk("rand_dones", 64'(dones_seen), 64'(m_done));
    chk("rand_not_full", 64'(full), 64'd0);

    // GAP_CYCLES=3 spacing with pt_valid kept high
    do_reset();
    send1(8'd0, 8'd0, 8'd0, 1'b0);
    send1(8'd1, 8'd0, 8'd0, 1'b0);
    send1(8'd2, 8'd0, 8'd0, 1'b0);
    send1(8'd3, 8'd0, 8'd0, 1'b0);
    tick(10);
    chk("gap_segs", 64'(s_segs), 64'd3);
    if (s_seg_cyc.size() == 3) begin
      chk("gap_spacing_1", 64'(s_seg_cyc[1] - s_seg_cyc[0]), 64'd6);
      chk("gap_spacing_2", 64'(s_seg_cyc[2] - s_seg_cyc[1]), 64'd6);
    end
    chk("gap_full", 64'(s_full), 64'd1);

    // MAX_SEGS=3: six vertices streamed, FULL is sticky
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 8'(i * 7), 8'(i), 8'd9, 1'b0, 40, ok);
      if (ok) acc++;
    end
    chk("full_accepted", 64'(acc), 64'd4);
    chk("full_segs", 64'(s_segs), 64'd3);
    chk("full_seg_count", s_seg_count, 64'd3);
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("full_hold", {s_full, s_ready, s_busy, s_seg_val}, 64'h8);
      tick(1);
    end
    s_valid = 1'b0;
    chk("full_no_more_segs", 64'(s_segs), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
